// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - job request and shift-register command bundle for shift_seq_ctrl
interface shift_seq_ctrl_if;
  logic       start;
  logic [3:0] din;
  logic [2:0] cnt;
  logic       rot;
  logic       fill;
  logic       abort;
  logic       q0;
  logic       sh;
  logic       l;
  logic [3:0] d;
  logic       si;
  logic       ready;
  logic       bit_data;
  logic       bit_vld;
  logic       done;

  modport slave (
    input  start, din, cnt, rot, fill, abort, q0,
    output sh, l, d, si, ready, bit_data, bit_vld, done
  );

  modport master (
    output start, din, cnt, rot, fill, abort, q0,
    input  sh, l, d, si, ready, bit_data, bit_vld, done
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - load-and-shift sequencer driving an external 4-bit shift register
module shift_seq_ctrl #(
  parameter int DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAIT, FIN} state_t;

  localparam logic [3:0] WAIT_LEN = 4'(DIV - 1);

  state_t     state, state_nx;
  // Shadow of the external register: lets every output stay registered while
  // still presenting the bit that Q0 will show during the coming shift cycle.
  logic [3:0] sreg, sreg_nx;
  logic       rot_q, rot_nx;
  logic       fill_q, fill_nx;
  logic [2:0] rem, rem_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic       pred_q0;
  logic       sh_nx, l_nx, si_nx, ready_nx, bit_nx, vld_nx, done_nx;
  logic [3:0] d_nx;

  // next-state and next-output decode
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    rot_nx   = rot_q;
    fill_nx  = fill_q;
    rem_nx   = rem;
    wcnt_nx  = wcnt;
    pred_q0  = sreg[0];
    sh_nx    = 1'b0;
    l_nx     = 1'b0;
    d_nx     = bus.d;
    si_nx    = bus.si;
    bit_nx   = bus.bit_data;
    vld_nx   = 1'b0;
    done_nx  = 1'b0;
    ready_nx = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx = LOAD;
          l_nx     = 1'b1;
          d_nx     = bus.din;
          sreg_nx  = bus.din;
          rot_nx   = bus.rot;
          fill_nx  = bus.fill;
          // 0 and anything above 4 both mean a full 4-bit pass
          rem_nx   = (bus.cnt >= 3'd1 && bus.cnt <= 3'd4) ? bus.cnt : 3'd4;
        end else begin
          ready_nx = 1'b1;
        end
      end
      LOAD: state_nx = SHIFT;
      SHIFT: begin
        sreg_nx = {bus.si, sreg[3:1]};
        rem_nx  = rem - 3'd1;
        if (rem == 3'd1) begin
          state_nx = FIN;
        end else if (DIV == 1) begin
          state_nx = SHIFT;
          pred_q0  = sreg[1];
        end else begin
          state_nx = WAIT;
          wcnt_nx  = WAIT_LEN;
        end
      end
      WAIT: begin
        if (wcnt <= 4'd1) begin
          state_nx = SHIFT;
          pred_q0  = bus.q0;
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end
      FIN: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
    endcase

    if (state_nx == SHIFT) begin
      sh_nx  = 1'b1;
      vld_nx = 1'b1;
      bit_nx = pred_q0;
      si_nx  = rot_q ? pred_q0 : fill_q;
    end
    if (state_nx == FIN) begin
      done_nx = 1'b1;
    end

    // cancel wins over everything once a job is in flight
    if (state != IDLE && bus.abort) begin
      state_nx = IDLE;
      sh_nx    = 1'b0;
      l_nx     = 1'b0;
      vld_nx   = 1'b0;
      done_nx  = 1'b0;
      ready_nx = 1'b1;
      bit_nx   = bus.bit_data;
      si_nx    = bus.si;
    end
  end

  // state, job context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sreg         <= '0;
      rot_q        <= 1'b0;
      fill_q       <= 1'b0;
      rem          <= '0;
      wcnt         <= '0;
      bus.sh       <= 1'b0;
      bus.l        <= 1'b0;
      bus.d        <= '0;
      bus.si       <= 1'b0;
      bus.ready    <= 1'b1;
      bus.bit_data <= 1'b0;
      bus.bit_vld  <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state        <= state_nx;
      sreg         <= sreg_nx;
      rot_q        <= rot_nx;
      fill_q       <= fill_nx;
      rem          <= rem_nx;
      wcnt         <= wcnt_nx;
      bus.sh       <= sh_nx;
      bus.l        <= l_nx;
      bus.d        <= d_nx;
      bus.si       <= si_nx;
      bus.ready    <= ready_nx;
      bus.bit_data <= bit_nx;
      bus.bit_vld  <= vld_nx;
      bus.done     <= done_nx;
    end
  end

endmodule
